// File: rtl/countdown_mmss.sv
// BCD mm:ss countdown timer: loads a checked preset, decrements on each 1 Hz tick in RUN,
// pulses done at 00:00. Define AUTO_RELOAD_EN to reload from the preset at expiry (periodic mode).
module countdown_mmss #(
    parameter int MIN_H_MAX = 9
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       tick,
    input  logic       load,
    input  logic       start,
    input  logic       stop,
    input  logic [3:0] pre_min_H,
    input  logic [3:0] pre_min_L,
    input  logic [3:0] pre_sec_H,
    input  logic [3:0] pre_sec_L,
    output logic [3:0] min_H,
    output logic [3:0] min_L,
    output logic [3:0] sec_H,
    output logic [3:0] sec_L,
    output logic       running,
    output logic       done,
    output logic       err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSE,
        S_EXPIRED
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [15:0] r_cnt, w_cnt_nxt;
    logic [15:0] r_pre, w_pre_nxt;
    logic        r_done, w_done_nxt;
    logic        r_err, w_err_nxt;
    logic [15:0] w_pre_in, w_cnt_dec;
    logic        w_legal, w_cnt_zero, w_dec_zero;

    // One-second BCD borrow chain on {min_H, min_L, sec_H, sec_L}; caller never passes 00:00.
    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        logic [3:0] mh, ml, sh, sl;
        mh = v[15:12];
        ml = v[11:8];
        sh = v[7:4];
        sl = v[3:0];
        if (sl == 4'd0) begin
            sl = 4'd9;
            if (sh == 4'd0) begin
                sh = 4'd5;
                if (ml == 4'd0) begin
                    ml = 4'd9;
                    mh = mh - 4'd1;
                end else begin
                    ml = ml - 4'd1;
                end
            end else begin
                sh = sh - 4'd1;
            end
        end else begin
            sl = sl - 4'd1;
        end
        return {mh, ml, sh, sl};
    endfunction

    assign w_pre_in   = {pre_min_H, pre_min_L, pre_sec_H, pre_sec_L};
    assign w_legal    = (pre_min_H <= 4'(MIN_H_MAX)) && (pre_min_L <= 4'd9) &&
                        (pre_sec_H <= 4'd5) && (pre_sec_L <= 4'd9);
    assign w_cnt_zero = (r_cnt == 16'h0000);
    assign w_cnt_dec  = bcd_dec(r_cnt);
    assign w_dec_zero = (w_cnt_dec == 16'h0000);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state <= S_IDLE;
            r_cnt   <= 16'h0000;
            r_pre   <= 16'h0000;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pre   <= w_pre_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pre_nxt   = r_pre;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        if (load) begin
            if (w_legal) begin
                w_cnt_nxt   = w_pre_in;
                w_pre_nxt   = w_pre_in;
                w_state_nxt = S_IDLE;
            end else begin
                w_err_nxt = 1'b1;
            end
        end else if (stop) begin
            if (r_state == S_RUN) begin
                w_state_nxt = S_PAUSE;
            end
        end else if (start) begin
            if ((r_state == S_IDLE || r_state == S_PAUSE) && !w_cnt_zero) begin
                w_state_nxt = S_RUN;
            end
        end else if (tick && r_state == S_RUN && !w_cnt_zero) begin
            if (w_dec_zero) begin
                w_done_nxt = 1'b1;
`ifdef AUTO_RELOAD_EN
                if (r_pre != 16'h0000) begin
                    w_cnt_nxt = r_pre;
                end else begin
                    w_cnt_nxt   = 16'h0000;
                    w_state_nxt = S_EXPIRED;
                end
`else
                w_cnt_nxt   = 16'h0000;
                w_state_nxt = S_EXPIRED;
`endif
            end else begin
                w_cnt_nxt = w_cnt_dec;
            end
        end
    end

    assign min_H   = r_cnt[15:12];
    assign min_L   = r_cnt[11:8];
    assign sec_H   = r_cnt[7:4];
    assign sec_L   = r_cnt[3:0];
    assign running = (r_state == S_RUN);
    assign done    = r_done;
    assign err     = r_err;

endmodule

// File: tb/tb_countdown_mmss.sv
// Directed bench for countdown_mmss: expectations queued per step, popped and checked
// one cycle later. Honours AUTO_RELOAD_EN for the periodic-timer expectations.
module tb_countdown_mmss;
    localparam int MIN_H_MAX = 9;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       tick = 1'b0, load = 1'b0, start = 1'b0, stop = 1'b0;
    logic [3:0] pre_min_H = 4'd0, pre_min_L = 4'd0, pre_sec_H = 4'd0, pre_sec_L = 4'd0;
    logic [3:0] min_H, min_L, sec_H, sec_L;
    logic       running, done, err;

    typedef struct {
        logic [18:0] v;
        string       tag;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;

    countdown_mmss #(.MIN_H_MAX(MIN_H_MAX)) dut (
        .clk(clk), .clr(clr), .tick(tick), .load(load), .start(start), .stop(stop),
        .pre_min_H(pre_min_H), .pre_min_L(pre_min_L),
        .pre_sec_H(pre_sec_H), .pre_sec_L(pre_sec_L),
        .min_H(min_H), .min_L(min_L), .sec_H(sec_H), .sec_L(sec_L),
        .running(running), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] bcd(input int m, input int s);
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    task automatic expect_push(input logic [15:0] cnt, input bit r, input bit d, input bit e,
                               input string tag);
        exp_t x;
        x.v   = {cnt, r, d, e};
        x.tag = tag;
        q.push_back(x);
    endtask

    task automatic check_pop();
        exp_t        x;
        logic [18:0] obs;
        x   = q.pop_front();
        obs = {min_H, min_L, sec_H, sec_L, running, done, err};
        vectors++;
        assert (obs === x.v)
        else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h (digits,run,done,err)", x.tag, obs, x.v);
        end
    endtask

    // Drive one cycle of inputs at negedge, sample 1 time unit after the next posedge.
    task automatic step(input bit ld, input bit st, input bit sp, input bit tk,
                        input logic [15:0] pre, input logic [15:0] ecnt,
                        input bit er, input bit ed, input bit ee, input string tag);
        @(negedge clk);
        load = ld; start = st; stop = sp; tick = tk;
        {pre_min_H, pre_min_L, pre_sec_H, pre_sec_L} = pre;
        expect_push(ecnt, er, ed, ee, tag);
        @(posedge clk);
        #1;
        check_pop();
    endtask

    initial begin
        // Reset
        #2;
        expect_push(16'h0000, 1'b0, 1'b0, 1'b0, "reset");
        check_pop();
        @(negedge clk);
        clr = 1'b0;

        // Load and full 60-tick countdown
        step(1, 0, 0, 0, 16'h0100, 16'h0100, 0, 0, 0, "load_0100");
        step(0, 1, 0, 0, 16'h0000, 16'h0100, 1, 0, 0, "start_0100");
        for (int i = 1; i <= 60; i++) begin
            step(0, 0, 0, 1, 16'h0000, bcd(0, 60 - i), (i < 60), (i == 60), 0, "count60");
        end
        step(0, 0, 0, 1, 16'h0000, 16'h0000, 0, 0, 0, "expired_tick");
        step(0, 1, 0, 1, 16'h0000, 16'h0000, 0, 0, 0, "expired_start");

        // Multi-digit borrow
        step(1, 0, 0, 0, 16'h1000, 16'h1000, 0, 0, 0, "load_1000");
        step(0, 1, 0, 0, 16'h0000, 16'h1000, 1, 0, 0, "start_1000");
        step(0, 0, 0, 1, 16'h0000, 16'h0959, 1, 0, 0, "borrow_0959");
        step(1, 0, 0, 0, 16'h0010, 16'h0010, 0, 0, 0, "load_0010");
        step(0, 1, 0, 0, 16'h0000, 16'h0010, 1, 0, 0, "start_0010");
        step(0, 0, 0, 1, 16'h0000, 16'h0009, 1, 0, 0, "borrow_0009");

        // Pause and priority
        step(1, 0, 0, 0, 16'h0031, 16'h0031, 0, 0, 0, "load_0031");
        step(0, 1, 0, 0, 16'h0000, 16'h0031, 1, 0, 0, "start_0031");
        step(0, 0, 0, 1, 16'h0000, 16'h0030, 1, 0, 0, "tick_0030");
        step(0, 0, 1, 1, 16'h0000, 16'h0030, 0, 0, 0, "stop_tick");
        step(0, 0, 0, 1, 16'h0000, 16'h0030, 0, 0, 0, "pause_tick");
        step(0, 1, 0, 1, 16'h0000, 16'h0030, 1, 0, 0, "resume");
        step(0, 0, 0, 1, 16'h0000, 16'h0029, 1, 0, 0, "tick_0029");
        step(1, 0, 0, 1, 16'h0200, 16'h0200, 0, 0, 0, "load_tick");

        // Illegal presets
        step(1, 0, 0, 0, 16'h0060, 16'h0200, 0, 0, 1, "illegal_secH");
        step(0, 0, 0, 0, 16'h0000, 16'h0200, 0, 0, 0, "err_clears");
        step(1, 0, 0, 0, {4'(MIN_H_MAX + 1), 12'h000}, 16'h0200, 0, 0, 1, "illegal_minH");
        step(1, 0, 0, 0, 16'h000A, 16'h0200, 0, 0, 1, "illegal_secL");
        step(1, 0, 0, 0, 16'h9959, 16'h9959, 0, 0, 0, "load_max");
        step(1, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, "load_0000");
        step(0, 1, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, "start_zero");

        // Asynchronous clear mid-run
        step(1, 0, 0, 0, 16'h0016, 16'h0016, 0, 0, 0, "load_0016");
        step(0, 1, 0, 0, 16'h0000, 16'h0016, 1, 0, 0, "start_0016");
        step(0, 0, 0, 1, 16'h0000, 16'h0015, 1, 0, 0, "tick_0015");
        #1;
        clr = 1'b1;
        #1;
        expect_push(16'h0000, 1'b0, 1'b0, 1'b0, "async_clr");
        check_pop();
        @(negedge clk);
        clr = 1'b0;

        // Expiry from 00:02, one-shot or periodic
        step(1, 0, 0, 0, 16'h0002, 16'h0002, 0, 0, 0, "load_0002");
        step(0, 1, 0, 0, 16'h0000, 16'h0002, 1, 0, 0, "start_0002");
`ifdef AUTO_RELOAD_EN
        step(0, 0, 0, 1, 16'h0000, 16'h0001, 1, 0, 0, "ar_t1");
        step(0, 0, 0, 1, 16'h0000, 16'h0002, 1, 1, 0, "ar_t2");
        step(0, 0, 0, 1, 16'h0000, 16'h0001, 1, 0, 0, "ar_t3");
        step(0, 0, 0, 1, 16'h0000, 16'h0002, 1, 1, 0, "ar_t4");
`else
        step(0, 0, 0, 1, 16'h0000, 16'h0001, 1, 0, 0, "os_t1");
        step(0, 0, 0, 1, 16'h0000, 16'h0000, 0, 1, 0, "os_t2");
        step(0, 0, 0, 1, 16'h0000, 16'h0000, 0, 0, 0, "os_t3");
        step(0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, "os_idle");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/countdown_mmss.md
Name: countdown_mmss

Overview:
BCD minutes:seconds countdown timer, the down-counting counterpart of the clock's up-counting second/minute chain. It loads a BCD preset, decrements once per qualified 1 Hz tick, and raises a one-cycle done pulse on reaching 00:00. Its digit outputs feed the same 7-segment display mux as the clock counters, and its tick input comes from the shared 1 Hz enable.

Parameters:
MIN_H_MAX, 9, maximum legal minute-tens digit (range 1..9).

Ports:
clk  input  1  system clock
clr  input  1  asynchronous reset, active-high
tick  input  1  1-cycle-wide count enable (1 Hz strobe, synchronous to clk)
load  input  1  latch preset into counter and preset register
start  input  1  begin/resume counting
stop  input  1  pause counting
pre_min_H  input  4  preset minute tens (BCD)
pre_min_L  input  4  preset minute units (BCD)
pre_sec_H  input  4  preset second tens (BCD, 0..5)
pre_sec_L  input  4  preset second units (BCD)
min_H  output  4  current minute tens
min_L  output  4  current minute units
sec_H  output  4  current second tens
sec_L  output  4  current second units
running  output  1  high while in RUN
done  output  1  one-cycle pulse on expiry
err  output  1  one-cycle pulse on rejected load

Behaviour:
- Reset: clr is asynchronous and active-high; the clock is clk. On clr: all digits and preset register = 0, state IDLE, running/done/err = 0. Asserting clr mid-run clears everything immediately, without waiting for a clock edge.
- Registered outputs: every output changes on the clk edge that samples the causing input, so latency is 1 cycle.
- States:
  - IDLE: loaded, not counting.
  - RUN: counting; running=1.
  - PAUSE: halted mid-count.
  - EXPIRED: reached 00:00.
- Input priority per cycle: load > stop > start > tick.
- load, legal preset (all unit digits ≤9, pre_sec_H ≤5, pre_min_H ≤ MIN_H_MAX):
  - counter and preset register take the preset value.
  - state goes to IDLE from any state.
  - all other inputs are ignored that cycle.
- load, illegal preset: err=1 for one cycle; counter, preset register and state are unchanged.
- start in IDLE or PAUSE:
  - count ≠ 00:00: go to RUN.
  - count = 00:00: stay in the current state; no done.
  - Ignored in RUN and EXPIRED.
- stop in RUN: go to PAUSE; no decrement even if tick is high. Ignored in other states.
- tick in RUN, BCD borrow chain:
  - sec_L: 0→9 with borrow, else −1.
  - sec_H: on borrow, 0→5 with borrow, else −1.
  - min_L: on borrow, 0→9 with borrow, else −1.
  - min_H: on borrow, −1.
  - tick outside RUN has no effect.
- Expiry: a tick in RUN with count = 00:01 gives count 00:00, done=1 for that one cycle, state EXPIRED, running=0.
  - EXPIRED holds 00:00.
  - Only load (to IDLE) or clr leaves EXPIRED.
- Wrap-around: the counter never decrements below 00:00.
- tick width: tick is assumed one cycle wide. A tick held high for N cycles decrements N times; this is legal and must not corrupt the BCD value.
- No illegal digit value (>9, or sec_H >5) may ever appear on the outputs.

Optional Feature:
AUTO_RELOAD_EN
- Defined, at expiry:
  - count reloads from the preset register instead of 00:00.
  - done pulses as usual and state stays RUN (periodic timer).
  - If the preset register is 00:00, normal EXPIRED behaviour applies.
- Undefined: one-shot behaviour as specified above.

Test Plan:
1. Reset and load: pulse clr -> all digits 0, running=0, done=0; then load 01:00 -> outputs 01:00 next cycle, state IDLE.
2. Full countdown: load 01:00, start, 60 ticks:
   - tick 1 -> 00:59.
   - tick 60 -> 00:00 with done high exactly one cycle, running=0.
   - further ticks and start -> no change.
3. Multi-digit borrow: load 10:00, start, 1 tick -> 09:59. Load 00:10, 1 tick -> 00:09.
4. Pause and priority:
   - In RUN at 00:30, stop and tick in the same cycle -> 00:30, PAUSE.
   - start then tick -> 00:29.
   - load 02:00 with tick in the same cycle -> 02:00, IDLE.
5. Illegal preset: load 00:60 or min_H=MIN_H_MAX+1 -> err one cycle; counter and preset register unchanged. start on 00:00 -> running stays 0.
6. Async clear and AUTO_RELOAD_EN:
   - clr mid-run at 00:15 -> outputs 0 before the next clk edge.
   - With AUTO_RELOAD_EN, preset 00:02, start, 4 ticks -> 00:01, 00:02 (done pulse), 00:01, 00:02 (done pulse); running stays 1.
